// File: rtl/i2s_master_xcvr.sv
`timescale 1ns/1ps
// i2s_master_xcvr: full-duplex I2S master.
// Divides sys_clk into BCLK/LRCK, shifts a stereo TX frame out MSB-first with
// the one-BCLK I2S delay and zero padding, and captures the ADC stream into a
// stereo RX frame.
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   i2s_bclk/lrck/dacdat      serial outputs to the codec
//   i2s_adcdat                serial input from the codec
//   tx_l/r_data, tx_valid     TX frame offer into the holding register
//   tx_ready                  holding register empty
//   tx_underrun               pulse: frame start with empty holding register
//   rx_l/r_data, rx_valid     captured RX frame with one-cycle strobe
module i2s_master_xcvr #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_dacdat,
  input  logic              i2s_adcdat,
  input  logic [DATA_W-1:0] tx_l_data,
  input  logic [DATA_W-1:0] tx_r_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_l_data,
  output logic [DATA_W-1:0] rx_r_data,
  output logic              rx_valid
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0]  RISE_CNT = DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0]  FALL_CNT = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0]  SLOT_B   = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0]  DATA_B   = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0]  ONE_B    = BIT_W'(1);
  localparam logic [BIT_W-1:0]  RX_DONE  = BIT_W'(SLOT_W + DATA_W);
  localparam logic [DATA_W-1:0] ONE_D    = DATA_W'(1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              bclk_q, bclk_d;
  logic              lrck_q, lrck_d;
  logic              dac_q, dac_d;
  logic              tx_ready_q, tx_ready_d;
  logic              underrun_q, underrun_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0] txsh_l_q, txsh_l_d, txsh_r_q, txsh_r_d;
  logic [DATA_W-1:0] rxsh_l_q, rxsh_l_d, rxsh_r_q, rxsh_r_d;
  logic [DATA_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
  logic              rx_valid_q, rx_valid_d;

  logic              rise_tick_s, fall_tick_s, frame_start_s;
  logic [BIT_W-1:0]  nb_s, p_s, q_s;
  logic              nb_right_s, rx_right_s, rx_in_win_s;
  logic [DATA_W-1:0] tx_word_s, tx_mask_s, rx_mask_s;
  logic              dac_bit_s;

  assign i2s_bclk    = bclk_q;
  assign i2s_lrck    = lrck_q;
  assign i2s_dacdat  = dac_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = underrun_q;
  assign rx_l_data   = rx_l_q;
  assign rx_r_data   = rx_r_q;
  assign rx_valid    = rx_valid_q;

  // Next-state logic for the clock divider, serialiser, holding register and capture path.
  always_comb begin
    rise_tick_s   = (div_q == RISE_CNT);
    fall_tick_s   = (div_q == FALL_CNT);
    frame_start_s = fall_tick_s && (bit_q == BIT_LAST);

    // Bit position the serialiser moves to on this fall tick.
    nb_s       = (bit_q == BIT_LAST) ? '0 : bit_q + ONE_B;
    nb_right_s = (nb_s >= SLOT_B);
    p_s        = nb_right_s ? (nb_s - SLOT_B) : nb_s;
    tx_word_s  = nb_right_s ? txsh_r_q : txsh_l_q;
    tx_mask_s  = ONE_D << (DATA_B - p_s);
    // Slot position 0 is the I2S delay bit; positions past DATA_W are padding.
    if ((p_s >= ONE_B) && (p_s <= DATA_B)) begin
      dac_bit_s = |(tx_word_s & tx_mask_s);
    end else begin
      dac_bit_s = 1'b0;
    end

    // Capture position of the bit currently on the line.
    rx_right_s  = (bit_q >= SLOT_B);
    q_s         = rx_right_s ? (bit_q - SLOT_B) : bit_q;
    rx_in_win_s = (q_s >= ONE_B) && (q_s <= DATA_B);
    rx_mask_s   = ONE_D << (DATA_B - q_s);

    div_d      = fall_tick_s ? '0 : div_q + DIV_W'(1);
    bit_d      = bit_q;
    bclk_d     = bclk_q;
    lrck_d     = lrck_q;
    dac_d      = dac_q;
    tx_ready_d = tx_ready_q;
    underrun_d = 1'b0;
    first_d    = first_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    txsh_l_d   = txsh_l_q;
    txsh_r_d   = txsh_r_q;
    rxsh_l_d   = rxsh_l_q;
    rxsh_r_d   = rxsh_r_q;
    rx_l_d     = rx_l_q;
    rx_r_d     = rx_r_q;
    rx_valid_d = 1'b0;

    if (rise_tick_s) begin
      bclk_d = 1'b1;
    end else if (fall_tick_s) begin
      bclk_d = 1'b0;
      bit_d  = nb_s;
      lrck_d = nb_right_s;
      dac_d  = dac_bit_s;
    end else begin
      bclk_d = bclk_q;
    end

    // The holding register is full exactly when tx_ready is low.
    if (frame_start_s) begin
      first_d = 1'b0;
      if (!tx_ready_q) begin
        txsh_l_d   = hold_l_q;
        txsh_r_d   = hold_r_q;
        tx_ready_d = 1'b1;
      end else begin
        underrun_d = !first_q;
      end
    end else begin
      first_d = first_q;
    end

    // A load wins over the transfer so freshly offered data stays held.
    if (tx_valid && tx_ready_q) begin
      hold_l_d   = tx_l_data;
      hold_r_d   = tx_r_data;
      tx_ready_d = 1'b0;
    end else begin
      hold_l_d = hold_l_q;
    end

    if (rise_tick_s && rx_in_win_s) begin
      if (rx_right_s) begin
        rxsh_r_d = i2s_adcdat ? (rxsh_r_q | rx_mask_s) : (rxsh_r_q & ~rx_mask_s);
      end else begin
        rxsh_l_d = i2s_adcdat ? (rxsh_l_q | rx_mask_s) : (rxsh_l_q & ~rx_mask_s);
      end
    end else begin
      rxsh_l_d = rxsh_l_q;
    end

    // The last right-channel bit is sampled on this same tick, so publish
    // the updated shift values rather than the registered ones.
    if (rise_tick_s && (bit_q == RX_DONE)) begin
      rx_l_d     = rxsh_l_d;
      rx_r_d     = rxsh_r_d;
      rx_valid_d = 1'b1;
    end else begin
      rx_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset to the idle, first-frame state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_q      <= '0;
      bit_q      <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      dac_q      <= 1'b0;
      tx_ready_q <= 1'b1;
      underrun_q <= 1'b0;
      first_q    <= 1'b1;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      txsh_l_q   <= '0;
      txsh_r_q   <= '0;
      rxsh_l_q   <= '0;
      rxsh_r_q   <= '0;
      rx_l_q     <= '0;
      rx_r_q     <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bit_q      <= bit_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      dac_q      <= dac_d;
      tx_ready_q <= tx_ready_d;
      underrun_q <= underrun_d;
      first_q    <= first_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      txsh_l_q   <= txsh_l_d;
      txsh_r_q   <= txsh_r_d;
      rxsh_l_q   <= rxsh_l_d;
      rxsh_r_q   <= rxsh_r_d;
      rx_l_q     <= rx_l_d;
      rx_r_q     <= rx_r_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_i2s_master_xcvr.sv
`timescale 1ns/1ps
// Scoreboard bench for i2s_master_xcvr with the ADC input looped back from
// the DAC output. Expected serial bits, RX frames and underrun pulses are
// queued when stimulus is issued; a negedge monitor pops and compares them.
module tb_i2s_master_xcvr;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        i2s_bclk, i2s_lrck, i2s_dacdat, i2s_adcdat;
  logic [23:0] tx_l_data = 24'd0;
  logic [23:0] tx_r_data = 24'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx_underrun, rx_valid;
  logic [23:0] rx_l_data, rx_r_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  logic bclk_prev = 1'b0;

  logic [95:0] dac_q[$];
  logic [95:0] rx_q[$];
  logic [95:0] ur_q[$];

  assign i2s_adcdat = i2s_dacdat;

  i2s_master_xcvr #(.DATA_W(24), .SLOT_W(32), .BCLK_DIV(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_dacdat(i2s_dacdat),
    .i2s_adcdat(i2s_adcdat),
    .tx_l_data(tx_l_data), .tx_r_data(tx_r_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun),
    .rx_l_data(rx_l_data), .rx_r_data(rx_r_data), .rx_valid(rx_valid)
  );

  always #5 sys_clk = ~sys_clk;

  // Cycle index since reset release: value seen at a negedge is the cycle number.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {95'd0, act}, {95'd0, exp});
  endtask

  // Expected (cycle, lrck, dacdat) at each BCLK rise of frame f.
  task automatic push_frame(input int f, input logic [23:0] l, input logic [23:0] r, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      int p;
      logic lr;
      logic d;
      logic [23:0] w;
      lr = (b >= 32);
      p  = b % 32;
      w  = lr ? r : l;
      d  = (p >= 1 && p <= 24) ? w[24 - p] : 1'b0;
      dac_q.push_back({32'(256 * f + 4 * b + 2), 62'd0, lr, d});
    end
  endtask

  task automatic push_rx(input int c, input logic [23:0] l, input logic [23:0] r);
    rx_q.push_back({32'(c), 16'd0, l, r});
  endtask

  task automatic push_ur(input int c);
    ur_q.push_back({32'(c), 64'd0});
  endtask

  // Scoreboard monitor: compare whenever the DUT presents a bit, frame or pulse.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (i2s_bclk && !bclk_prev) begin
        if (dac_q.size() == 0) chk("dac_unexpected", {32'(cyc), 62'd0, i2s_lrck, i2s_dacdat}, 96'd0);
        else chk("dac_bit", {32'(cyc), 62'd0, i2s_lrck, i2s_dacdat}, dac_q.pop_front());
      end
      if (rx_valid) begin
        if (rx_q.size() == 0) chk("rx_unexpected", {32'(cyc), 16'd0, rx_l_data, rx_r_data}, 96'd0);
        else chk("rx_frame", {32'(cyc), 16'd0, rx_l_data, rx_r_data}, rx_q.pop_front());
      end
      if (tx_underrun) begin
        if (ur_q.size() == 0) chk("underrun_unexpected", {32'(cyc), 64'd0}, 96'd0);
        else chk("underrun", {32'(cyc), 64'd0}, ur_q.pop_front());
      end
    end
    bclk_prev <= i2s_bclk;
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  task automatic load(input logic [23:0] l, input logic [23:0] r);
    tx_l_data = l;
    tx_r_data = r;
    tx_valid  = 1'b1;
    @(negedge sys_clk);
    tx_valid  = 1'b0;
  endtask

  task automatic drain_check();
    chk("dac_q_left", 96'(dac_q.size()), 96'd0);
    chk("rx_q_left", 96'(rx_q.size()), 96'd0);
    chk("ur_q_left", 96'(ur_q.size()), 96'd0);
    dac_q.delete();
    rx_q.delete();
    ur_q.delete();
  endtask

  task automatic reset_vals(input string tag);
    chk1({tag, "_bclk"}, i2s_bclk, 1'b0);
    chk1({tag, "_lrck"}, i2s_lrck, 1'b0);
    chk1({tag, "_dacdat"}, i2s_dacdat, 1'b0);
    chk1({tag, "_tx_ready"}, tx_ready, 1'b1);
    chk1({tag, "_underrun"}, tx_underrun, 1'b0);
    chk1({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk({tag, "_rx_data"}, {48'd0, rx_l_data, rx_r_data}, 96'd0);
  endtask

  task automatic release_reset();
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Phase A: reset values, timing, TX pattern, underrun and loopback RX.
    repeat (2) @(negedge sys_clk);
    reset_vals("rst0");
    push_frame(0, 24'h0, 24'h0, 64);
    push_frame(1, 24'hA50F3C, 24'h800001, 64);
    push_frame(2, 24'hA50F3C, 24'h800001, 64);
    push_rx(226, 24'h0, 24'h0);
    push_rx(482, 24'hA50F3C, 24'h800001);
    push_rx(738, 24'hA50F3C, 24'h800001);
    push_ur(512);
    push_ur(768);
    release_reset();
    wait_cyc(1);   chk1("bclk_c1", i2s_bclk, 1'b0);
    wait_cyc(2);   chk1("bclk_c2", i2s_bclk, 1'b1);
    wait_cyc(3);   chk1("bclk_c3", i2s_bclk, 1'b1);
    wait_cyc(4);   chk1("bclk_c4", i2s_bclk, 1'b0);
    wait_cyc(100); chk1("ready_before_load", tx_ready, 1'b1);
    load(24'hA50F3C, 24'h800001);
    chk1("ready_after_load", tx_ready, 1'b0);
    wait_cyc(127); chk1("lrck_c127", i2s_lrck, 1'b0);
    wait_cyc(128); chk1("lrck_c128", i2s_lrck, 1'b1);
    wait_cyc(255); chk1("lrck_c255", i2s_lrck, 1'b1);
    chk1("ready_c255", tx_ready, 1'b0);
    wait_cyc(256); chk1("lrck_c256", i2s_lrck, 1'b0);
    chk1("ready_c256", tx_ready, 1'b1);
    wait_cyc(769);
    sys_rst_n = 1'b0;
    drain_check();

    // Phase B: asynchronous reset in the middle of the left slot of frame 1.
    push_frame(0, 24'h0, 24'h0, 64);
    push_frame(1, 24'h333333, 24'h444444, 12);
    push_rx(226, 24'h0, 24'h0);
    release_reset();
    wait_cyc(50);  load(24'h333333, 24'h444444);
    wait_cyc(270); chk1("ready_c270", tx_ready, 1'b1);
    load(24'h555555, 24'h666666);
    wait_cyc(302);
    #1;
    chk1("pre_rst_bclk", i2s_bclk, 1'b1);
    chk1("pre_rst_dacdat", i2s_dacdat, 1'b1);
    chk1("pre_rst_ready", tx_ready, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    reset_vals("async_rst");
    drain_check();

    // Phase C: silent first frame, then a tx_valid offered while the holding
    // register is full in the frame-start cycle.
    push_frame(0, 24'h0, 24'h0, 64);
    push_frame(1, 24'h0F0F0F, 24'hF0F0F0, 64);
    push_frame(2, 24'h111111, 24'h111111, 64);
    push_frame(3, 24'h222222, 24'h222222, 64);
    push_rx(226, 24'h0, 24'h0);
    push_rx(482, 24'h0F0F0F, 24'hF0F0F0);
    push_rx(738, 24'h111111, 24'h111111);
    push_rx(994, 24'h222222, 24'h222222);
    release_reset();
    wait_cyc(50);  load(24'h0F0F0F, 24'hF0F0F0);
    wait_cyc(300); chk1("ready_c300", tx_ready, 1'b1);
    load(24'h111111, 24'h111111);
    wait_cyc(511); chk1("ready_c511", tx_ready, 1'b0);
    tx_l_data = 24'h222222;
    tx_r_data = 24'h222222;
    tx_valid  = 1'b1;
    @(negedge sys_clk);
    chk1("ready_c512", tx_ready, 1'b1);
    @(negedge sys_clk);
    chk1("ready_c513", tx_ready, 1'b0);
    tx_valid = 1'b0;
    wait_cyc(1023);
    drain_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
